// File: rtl/clkdiv_pkg.sv
// ============================================================================
// Module  : clkdiv_pkg
// Brief   : Shared constants and divisor helpers for the programmable divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package clkdiv_pkg;

  localparam int MIN_DIV       = 2;
  localparam int DEFAULT_DIV_W = 16;

  // Helpers work on 32-bit values; callers cast to their own divisor width.
  function automatic logic [31:0] clamp_div(input logic [31:0] value);
    return (value < 32'(MIN_DIV)) ? 32'(MIN_DIV) : value;
  endfunction

  function automatic logic [31:0] high_len(input logic [31:0] n);
    return n - (n >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_divider_ch.sv
// ============================================================================
// Module  : clock_divider_ch
// Brief   : One divider channel; pending divisor is applied only at a period wrap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider_ch
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DEFAULT_DIV_W,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             load,
  output logic             load_ack,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] c_reset_div = DIV_W'(clamp_div(32'(DEFAULT_DIV)));

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_active;
  logic [DIV_W-1:0] r_pend;
  logic             r_pend_valid;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_load_ack;

  logic [DIV_W-1:0] w_high;
  logic [DIV_W-1:0] w_last;
  logic [DIV_W-1:0] w_load_div;
  logic             w_wrap;
  logic             w_apply;

  // A disabled edge counts as a wrap so pending divisors still drain.
  always_comb begin
    w_high     = DIV_W'(high_len(32'(r_active)));
    w_last     = r_active - DIV_W'(1);
    w_load_div = DIV_W'(clamp_div(32'(div_val)));
    w_wrap     = !en || (r_cnt == w_last);
    w_apply    = w_wrap && r_pend_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_active     <= c_reset_div;
      r_pend       <= c_reset_div;
      r_pend_valid <= 1'b0;
      r_clk_out    <= 1'b0;
      r_tick       <= 1'b0;
      r_load_ack   <= 1'b0;
    end else begin
      r_load_ack <= w_apply;
      if (w_apply) begin
        r_active     <= r_pend;
        r_pend_valid <= 1'b0;
      end
      // A load on the apply edge becomes the next pending value.
      if (load) begin
        r_pend       <= w_load_div;
        r_pend_valid <= 1'b1;
      end
      if (en) begin
        r_clk_out <= (r_cnt < w_high);
        r_tick    <= (r_cnt == '0);
        r_cnt     <= w_wrap ? '0 : r_cnt + DIV_W'(1);
      end else begin
        r_clk_out <= 1'b0;
        r_tick    <= 1'b0;
        r_cnt     <= '0;
      end
    end
  end

  assign load_ack = r_load_ack;
  assign clk_out  = r_clk_out;
  assign tick     = r_tick;

endmodule

`default_nettype wire

// File: rtl/clock_divider_prog.sv
// ============================================================================
// Module  : clock_divider_prog
// Brief   : NUM_CH independent programmable clock dividers with glitch-free reload.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = DEFAULT_DIV_W,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       load,
  output logic [NUM_CH-1:0]       load_ack,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clock_divider_ch #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en[gi]),
        .div_val  (div_val[gi*DIV_W +: DIV_W]),
        .load     (load[gi]),
        .load_ack (load_ack[gi]),
        .clk_out  (clk_out[gi]),
        .tick     (tick[gi])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
// ============================================================================
// Module  : tb_clock_divider_prog
// Brief   : Directed scoreboard bench for clock_divider_prog (channel 0 detail, 2-ch rates).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_divider_prog;

  logic        clk;
  logic        rst_n;
  logic [1:0]  en;
  logic [31:0] div_val;
  logic [1:0]  load;
  logic [1:0]  load_ack;
  logic [1:0]  clk_out;
  logic [1:0]  tick;

  typedef struct packed {
    logic co;
    logic tk;
    logic ak;
  } exp_t;

  exp_t sb_q[$];
  int   total;
  int   bad;

  clock_divider_prog #(
    .NUM_CH      (2),
    .DIV_W       (16),
    .DEFAULT_DIV (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_val  (div_val),
    .load     (load),
    .load_ack (load_ack),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected channel-0 outputs after each edge for counter values first..last of period n.
  task automatic push_range(input int n, input int first, input int last, input bit ack_last);
    exp_t e;
    for (int c = first; c <= last; c++) begin
      e.co = (c < (n - n / 2));
      e.tk = (c == 0);
      e.ak = ack_last && (c == last);
      sb_q.push_back(e);
    end
  endtask

  task automatic push_idle(input bit ak);
    exp_t e;
    e.co = 1'b0;
    e.tk = 1'b0;
    e.ak = ak;
    sb_q.push_back(e);
  endtask

  task automatic run(input int cycles);
    exp_t e;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      load = 2'b00;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow observed=empty expected=entry");
      end else begin
        e = sb_q.pop_front();
        check("clk_out0", 32'(clk_out[0]), 32'(e.co));
        check("tick0",    32'(tick[0]),    32'(e.tk));
        check("ack0",     32'(load_ack[0]), 32'(e.ak));
      end
    end
  endtask

  task automatic load0(input int value);
    load          = 2'b01;
    div_val[15:0] = 16'(value);
  endtask

  initial begin
    int cnt0;
    int cnt1;
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    en      = 2'b11;
    load    = 2'b00;
    div_val = '0;

    // Reset held with enable high
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_tick",    32'(tick),    32'd0);
      check("rst_ack",     32'(load_ack), 32'd0);
    end
    rst_n = 1'b1;

    // Default divisor 4
    push_range(4, 0, 3, 1'b0);
    push_range(4, 0, 3, 1'b0);
    run(8);

    // Odd divisor loaded at cnt=2
    push_range(4, 0, 1, 1'b0);
    run(2);
    load0(5);
    push_range(4, 2, 3, 1'b1);
    push_range(5, 0, 4, 1'b0);
    push_range(5, 0, 4, 1'b0);
    run(12);

    // Clamp 0 and 1 to 2
    load0(0);
    push_range(5, 0, 4, 1'b1);
    run(5);
    load0(1);
    push_range(2, 0, 1, 1'b1);
    push_range(2, 0, 1, 1'b0);
    push_range(2, 0, 1, 1'b0);
    run(6);

    // Overwrite: 8 then 6 inside one N=7 period, single ack
    load0(7);
    push_range(2, 0, 1, 1'b1);
    run(2);
    push_range(7, 0, 0, 1'b0);
    run(1);
    load0(8);
    push_range(7, 1, 2, 1'b0);
    run(2);
    load0(6);
    push_range(7, 3, 6, 1'b1);
    run(4);
    push_range(6, 0, 5, 1'b0);
    push_range(6, 0, 5, 1'b0);
    run(12);

    // Collision: load on the wrap edge with nothing pending
    push_range(6, 0, 4, 1'b0);
    run(5);
    load0(10);
    push_range(6, 5, 5, 1'b0);
    run(1);
    push_range(6, 0, 5, 1'b1);
    push_range(10, 0, 9, 1'b0);
    run(16);

    // Drop enable in the high phase, load while disabled, re-enable
    push_range(10, 0, 1, 1'b0);
    run(2);
    en[0] = 1'b0;
    push_idle(1'b0);
    push_idle(1'b0);
    run(2);
    load0(3);
    push_idle(1'b0);
    run(1);
    push_idle(1'b1);
    run(1);
    en[0] = 1'b1;
    push_range(3, 0, 2, 1'b0);
    push_range(3, 0, 2, 1'b0);
    run(6);

    // Asynchronous reset mid-period discards a pending load
    load0(9);
    push_range(3, 0, 0, 1'b0);
    run(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clk_out", 32'(clk_out), 32'd0);
    check("async_tick",    32'(tick),    32'd0);
    check("async_ack",     32'(load_ack), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_range(4, 0, 3, 1'b0);
    push_range(4, 0, 3, 1'b0);
    run(8);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    // Independent channels: ch0 N=3, ch1 N=7
    load    = 2'b11;
    div_val = {16'd7, 16'd3};
    repeat (3) begin
      @(posedge clk);
      #1;
      load = 2'b00;
    end
    @(posedge clk);
    #1;
    check("ack_both", 32'(load_ack), 32'd3);
    cnt0 = 0;
    cnt1 = 0;
    repeat (210) begin
      @(posedge clk);
      #1;
      cnt0 += int'(tick[0]);
      cnt1 += int'(tick[1]);
    end
    check("ticks_ch0", 32'(cnt0), 32'd70);
    check("ticks_ch1", 32'(cnt1), 32'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Multi-channel programmable clock divider; successor to the fixed single-output ClockDivider.
- Each channel derives a registered, glitch-free divided clock from clk with a runtime divisor and near-50% duty.
- Divisor changes take effect only at period boundaries, so downstream logic never sees a runt pulse.
- Used as the timebase generator for slow-rate logic (display scan, debounce, sequence sampling).

Parameters:
- NUM_CH, 2, number of independent divider channels (1..8)
- DIV_W, 16, width of each divisor value
- DEFAULT_DIV, 4, active divisor for every channel after reset (must be >= 2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  NUM_CH  per-channel run enable
- div_val  in  NUM_CH*DIV_W  requested divisors; channel i uses bits [i*DIV_W +: DIV_W]
- load  in  NUM_CH  1-cycle strobe; captures div_val slice into channel i's pending register
- load_ack  out  NUM_CH  1-cycle pulse when the pending divisor becomes active
- clk_out  out  NUM_CH  divided clock, direct register output
- tick  out  NUM_CH  1-cycle pulse coincident with each rising edge of clk_out

Behaviour:
- Reset (async assert, sync release): cnt=0, active=DEFAULT_DIV, pend_valid=0, clk_out=0, tick=0, load_ack=0.
- Divisor clamp: any captured value <2 (0 or 1) is stored as 2. Max N = 2^DIV_W-1.
- Duty: H = N - (N>>1) (ceil N/2). clk_out high for H cycles, low for N-H cycles.
- Counting (en=1): on each edge, c = cnt; clk_out <= (c < H); tick <= (c == 0); cnt <= (c == N-1) ? 0 : c+1.
  - Example, N=4 from cnt=0: clk_out 1,1,0,0,...; tick 1,0,0,0,...
  - Example, N=5: clk_out 1,1,1,0,0.
- Load handshake:
  - load[i]=1 captures clamped div_val into pending and sets pend_valid.
  - A second load while pending overwrites the pending value; only one ack is issued.
- Apply point: on the edge where cnt wraps N-1 -> 0, if pend_valid:
  - active <= pending, pend_valid <= 0, load_ack pulses in the following cycle.
  - The new period starts at cnt=0 with the new N.
- Simultaneous load and wrap on the same edge: the old pending value (if any) is applied; the new load becomes pending for the next wrap. With nothing previously pending, the new value waits one full period.
- en=0:
  - Next edge: cnt <= 0, clk_out <= 0, tick <= 0.
  - Any pending value is applied on that edge, with ack the next cycle.
  - Loads while disabled apply on the following edge.
- en re-asserted: the first enabled edge uses cnt=0, so clk_out rises and tick pulses; a clean period start.
- Dropping en mid-high truncates the high phase. This is the only permitted short pulse, and it is documented for consumers.
- Channels are fully independent; no cross-channel phase alignment.
- Reset mid-operation: all outputs go low immediately (async), and pending loads are discarded.

Decomposition:
- Package clkdiv_pkg:
  - constant MIN_DIV=2
  - default DIV_W
  - function clamp_div(value) -> max(value, MIN_DIV)
  - function high_len(N) -> N - (N>>1)
- Sub-module clock_divider_ch holds one channel (counter, active/pending registers, output regs). The top instantiates NUM_CH copies in a generate loop and slices the div_val bus.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with en=1 -> clk_out=0, tick=0, load_ack=0. Release -> channel 0 with DEFAULT_DIV=4 gives clk_out 1,1,0,0, period 4, tick every 4th cycle.
- Odd divisor: load 5 on ch0 while at cnt=2 of N=4 -> old period completes (2 more cycles), then load_ack pulses and clk_out shows 3 high / 2 low.
- Clamp: load 0 then 1 -> each behaves as N=2, clk_out toggling every cycle, one ack per apply.
- Overwrite and collision: load 8 then load 6 within one period -> a single ack, period 6. Load 10 on the wrap edge with nothing pending -> applies one full period later.
- Enable and reset: drop en during the high phase -> clk_out=0 next edge. Re-enable -> immediate rising edge plus tick. Assert rst_n mid-period -> outputs 0 within the same cycle (async); pending load discarded, DEFAULT_DIV restored.
- Independence: NUM_CH=2, ch0 N=3 and ch1 N=7 running simultaneously -> tick counts over 210 cycles are exactly 70 and 30.
